// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side request/grant/return signals plus the unified memory port of mem_port_arbiter.
// slave is the arbiter's view; master is the view of the stages and memory that surround it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              halt;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       stat_if_cnt;
  logic [15:0]       stat_d_cnt;

  modport slave (
    input  halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stat_if_cnt, stat_d_cnt
  );

  modport master (
    output halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stat_if_cnt, stat_d_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store: data has priority, fetch wins after STARVE_MAX losses.
// Grant counters are built only when ARB_STATS_EN is defined; otherwise the stat ports read zero.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              if_win;
  logic              if_gnt;
  logic              d_gnt;
  logic              rd_new;
  owner_e            own_new;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              if_rvalid;
  logic              d_rvalid;

  logic [3:0]         starve_q, starve_d;
  logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LAT-1:0] tag_own_q, tag_own_d;

  // Grants are gated by rst so every output reads zero while reset is held.
  always_comb begin
    if_win    = bus.if_req && (!bus.d_req || (starve_q == STARVE_LIM));
    if_gnt    = !rst && !bus.halt && if_win;
    d_gnt     = !rst && !bus.halt && bus.d_req && !if_win;
    rd_new    = if_gnt || (d_gnt && !bus.d_we);
    own_new   = d_gnt ? OWN_D : OWN_IF;
    win_addr  = '0;
    win_wdata = '0;
    if (d_gnt) begin
      win_addr  = bus.d_addr;
      win_wdata = bus.d_we ? bus.d_wdata : '0;
    end else if (if_gnt) begin
      win_addr  = bus.if_addr;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.halt) begin
      if (!bus.if_req || if_gnt) begin
        starve_d = '0;
      end else if (d_gnt && (starve_q < STARVE_LIM)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // Return tags advance one stage per cycle; the tail lines up with mem_rdata.
  always_comb begin
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = rd_new;
    tag_own_d[0] = own_new;
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q  <= '0;
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      starve_q  <= starve_d;
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  assign if_rvalid = tag_vld_q[MEM_LAT-1] && (tag_own_q[MEM_LAT-1] == OWN_IF);
  assign d_rvalid  = tag_vld_q[MEM_LAT-1] && (tag_own_q[MEM_LAT-1] == OWN_D);

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = if_gnt | d_gnt;
  assign bus.mem_we    = d_gnt & bus.d_we;
  assign bus.mem_addr  = win_addr;
  assign bus.mem_wdata = win_wdata;
  assign bus.if_rvalid = if_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = d_rvalid ? bus.mem_rdata : '0;

`ifdef ARB_STATS_EN
  logic [15:0] stat_if_q, stat_if_d;
  logic [15:0] stat_d_q, stat_d_d;

  always_comb begin
    stat_if_d = stat_if_q;
    stat_d_d  = stat_d_q;
    if (if_gnt && (stat_if_q != 16'hFFFF)) stat_if_d = stat_if_q + 16'd1;
    if (d_gnt && (stat_d_q != 16'hFFFF))   stat_d_d  = stat_d_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_if_q <= '0;
      stat_d_q  <= '0;
    end else begin
      stat_if_q <= stat_if_d;
      stat_d_q  <= stat_d_d;
    end
  end

  assign bus.stat_if_cnt = stat_if_q;
  assign bus.stat_d_cnt  = stat_d_q;
`else
  assign bus.stat_if_cnt = 16'h0000;
  assign bus.stat_d_cnt  = 16'h0000;
`endif
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single shared instruction/data memory between the fetch stage (read-only) and the load/store stage (read/write).
- Sits between the pipeline stages and the 1024x32 unified memory array.
- Fixed priority to data accesses, with a starvation guard for fetch.
- Return-path tagging routes pipelined read data back to the requester that issued it.

Parameters:
- ADDR_W, 10, word-address width (1024 words)
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles, legal 1..4
- STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win, legal 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- halt  in  1  pipeline halted; blocks new grants
- if_req  in  1  fetch read request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read strobe
- stat_if_cnt  out  16  fetch grant count (optional feature)
- stat_d_cnt  out  16  data grant count (optional feature)

Behaviour:
- Grant decision is combinational from the current requests and registered state. At most one grant per cycle. mem_en = if_gnt | d_gnt. mem_* fields come from the winner.
- halt=1: no grants, mem_en=0. In-flight reads still complete and return rvalid.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: d wins unless starve_cnt == STARVE_MAX, in which case if wins.
- starve_cnt (4 bit), updated on the clock edge:
  - Cleared when if_gnt=1, or when if_req=0.
  - Incremented when if_req=1, d_gnt=1, and halt=0.
  - Unchanged while halt=1.
  - Never exceeds STARVE_MAX.
- Return path: a MEM_LAT-deep shift register of {valid, owner} entries.
  - Loaded at the head with valid=1 on every granted read (if read, or d read with d_we=0).
  - Stores load valid=0.
  - At the tail: if_rvalid = valid & owner==IF; d_rvalid = valid & owner==D.
  - rdata outputs = mem_rdata when the matching rvalid is 1, else 0.
  - Back-to-back reads are fully pipelined: one read accepted per cycle, one returned per cycle.
- Store: mem_we=1 in the grant cycle; no rvalid is produced. A load to the same address granted next cycle returns the stored data (the memory guarantees write-before-read).
- Outputs follow the grant: gnt outputs are combinational; rvalid/rdata derive from registered tags.
- Reset (async assert): all tag entries invalid, starve_cnt=0, stat counters=0. All outputs read 0 while rst=1 (grants gated by rst). Reads in flight at reset are discarded; no rvalid after release.
- Requests with addr beyond 2^ADDR_W cannot occur (width-limited). No address checking.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: stat_if_cnt/stat_d_cnt increment on each if_gnt/d_gnt, saturate at 16'hFFFF, and clear on rst.
- Undefined: counters are not built; both ports are tied to 16'h0000.

Test Plan:
- Single fetch, MEM_LAT=1:
  - Stimulus: if_req=1, if_addr=5, mem[5]=32'hDEADBEEF.
  - Response: if_gnt same cycle, mem_addr=5; next cycle if_rvalid=1, if_rdata=32'hDEADBEEF, d_rvalid=0.
- Contention with starvation, STARVE_MAX=4:
  - Stimulus: if_req and d_req (loads) held high for 10 cycles.
  - Response: grant sequence D,D,D,D,IF,D,D,D,D,IF.
  - Every rvalid is routed to the correct owner in issue order.
- Store then load:
  - Stimulus: d store addr 12, data 32'h0000_00A5; next cycle d load addr 12.
  - Response: mem_we=1 only in the first grant; d_rvalid=1 with 32'h0000_00A5 one cycle after the load grant; no rvalid for the store.
- Halt:
  - Stimulus: assert halt while one fetch read is in flight and d_req=1.
  - Response: in-flight if_rvalid still fires; no grants and mem_en=0 while halted; d wins on the first cycle after release.
- Reset mid-read, MEM_LAT=3:
  - Stimulus: grant two reads, then pulse rst for one cycle.
  - Response: no rvalid after release; starve_cnt=0; stat counters=0.
- ARB_STATS_EN defined:
  - Stimulus: 70000 consecutive fetch grants.
  - Response: stat_if_cnt=16'hFFFF (saturated), stat_d_cnt=0.
  - Same test with the macro undefined: both counters read 0.
